text_vram_ctrl: RTL and testbench
=================================

Name: text_vram_ctrl

Overview:
Sequences all writes into the character VRAM that feeds the VGA text scanout, and arbitrates the single VRAM port between the VGA scanout reader and the UART character stream. Interprets received ASCII as a terminal: writes printable characters at the cursor and handles CR/LF/BS/FF. Scrolls using a ring-buffer top-row offset rather than moving data. Sits between the UART receiver's ASCII output and the VRAM, beside the VGA timing counters.

Parameters:
COLS, 80, characters per row (640 px / 8 px font width)
ROWS, 30, character rows (480 px / 16 px font height)
ADDR_W, 12, VRAM address width; must satisfy 2^ADDR_W >= COLS*ROWS

Ports:
Clk  in  1  system clock
Rst  in  1  asynchronous, active-high reset
char_valid  in  1  UART byte available
char_data  in  8  ASCII byte
char_ready  out  1  controller can accept a byte this cycle
scan_req  in  1  VGA scanout needs the VRAM port this cycle
scan_addr  in  ADDR_W  scanout read address (already offset by top_row)
vram_addr  out  ADDR_W  VRAM address (combinational mux)
vram_wdata  out  8  VRAM write data
vram_we  out  1  VRAM write enable
top_row  out  5  physical row currently displayed as screen row 0
cursor_col  out  7  logical cursor column, 0..COLS-1
cursor_row  out  5  logical cursor row, 0..ROWS-1
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, Rst=1): state=IDLE; cursor_col=0, cursor_row=0, top_row=0; vram_we=0; char_ready=0 while Rst=1; busy=0.
- States: IDLE, WRITE, CLR_LINE, CLR_ALL.
- Handshake: char_ready=1 only in IDLE with Rst=0. A byte is accepted on the rising edge with char_valid&&char_ready. char_valid while char_ready=0 is not consumed; the source must hold it.
- Physical address: (((cursor_row+top_row) mod ROWS)*COLS + cursor_col). All modulo arithmetic uses compare-and-subtract; no divider.
- Arbitration: scan_req has absolute priority. While scan_req=1: vram_addr=scan_addr, vram_we=0, and every write state holds its registers (stall). A write commits only on a cycle with scan_req=0.
- Accepted byte handling:
  - 0x20..0x7E: go to WRITE; write the byte at the cursor, then advance cursor_col. At col COLS-1, the write is followed by col=0 plus a newline.
  - 0x0D (CR): cursor_col=0; stay IDLE; no VRAM write.
  - 0x0A (LF): newline.
  - 0x08 (BS): if col>0, col-1 then WRITE 0x20 at the new position without advancing. If col=0, no-op.
  - 0x0C (FF): go to CLR_ALL; afterwards cursor=(0,0) and top_row=0.
  - Any other byte: consumed and ignored.
- Newline: if cursor_row<ROWS-1, cursor_row+1 and return to IDLE. Otherwise top_row=(top_row+1) mod ROWS, cursor_row stays ROWS-1, and the FSM enters CLR_LINE.
- CLR_LINE: writes 0x20 to all COLS cells of the new bottom physical row (the old top_row), col 0 upward. Takes COLS non-stalled cycles, then returns to IDLE.
- CLR_ALL: writes 0x20 to addresses 0..COLS*ROWS-1 in order, then returns to IDLE.
- Latency: a printable byte is written on the first non-stalled cycle after acceptance. char_ready returns the cycle after the commit (or after the final clear write).
- Rst asserted mid-clear: the clear aborts immediately and untouched cells keep their old contents.

Optional Feature:
VRAM_CLEAR_ON_RESET_EN
- Defined: on Rst release the FSM enters CLR_ALL instead of IDLE. char_ready=0 and busy=1 until all COLS*ROWS cells hold 0x20, so the screen never shows power-up garbage.
- Undefined: the FSM enters IDLE directly and VRAM contents are undefined.

Test Plan:
- Send "AB" with scan_req=0 → vram_we pulses at addr 0 (0x41) and addr 1 (0x42); cursor_col=2; char_ready low exactly one cycle per byte.
- Hold scan_req=1 for 5 cycles during a write of 'Z' → vram_addr tracks scan_addr and vram_we=0 for 5 cycles; 'Z' commits on the first scan_req=0 cycle.
- Cursor at (29,79), send 'Q' → 'Q' written at addr 29*80+79=2399; top_row becomes 1; 80 writes of 0x20 at addr 0..79; cursor=(29,0).
- With top_row=1, cursor=(29,5), send BS → 0x20 written at addr ((29+1) mod 30)*80+4=4; cursor_col=4.
- Send 0x0C → 2400 writes of 0x20 at addr 0..2399; cursor=(0,0); top_row=0; busy high throughout.
- Assert Rst mid-CLR_ALL at address 1000 → next edge has vram_we=0, state IDLE, and no further writes; with VRAM_CLEAR_ON_RESET_EN defined, a full clear restarts at addr 0 after release.

Source files
------------

// File: rtl/text_vram_ctrl.sv
// Terminal-style write sequencer for the character VRAM; scanout reads always win the port.
// Optional: define VRAM_CLEAR_ON_RESET_EN to blank the whole screen after every reset release.
module text_vram_ctrl #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_wdata,
    output logic              vram_we,
    output logic [4:0]        top_row,
    output logic [6:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, WRITE, CLR_LINE, CLR_ALL} state_t;

    localparam logic [6:0]        COL_LAST  = 7'(COLS - 1);
    localparam logic [4:0]        ROW_LAST  = 5'(ROWS - 1);
    localparam logic [5:0]        ROW_NUM   = 6'(ROWS);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(COLS * ROWS - 1);
`ifdef VRAM_CLEAR_ON_RESET_EN
    localparam logic INIT_CLEAR = 1'b1;
`else
    localparam logic INIT_CLEAR = 1'b0;
`endif

    state_t            state, state_nxt;
    logic [7:0]        wr_data;
    logic              wr_advance;
    logic [4:0]        line_row;
    logic [ADDR_W-1:0] clr_cnt;
    logic              init_pend;

    logic              accept, stall, is_print, is_bs, is_ff, at_bottom, do_newline;
    logic [5:0]        row_sum;
    logic [4:0]        phys_row, top_next;
    logic [ADDR_W-1:0] wr_addr;

    // Handshake: a byte transfers on a rising edge where char_valid && char_ready;
    // char_ready is high only in IDLE, so a held char_valid simply waits.
    assign accept    = char_valid && char_ready;
    assign stall     = scan_req;
    assign is_print  = (char_data >= 8'h20) && (char_data <= 8'h7E);
    assign is_bs     = (char_data == 8'h08) && (cursor_col != 7'd0);
    assign is_ff     = (char_data == 8'h0C);
    assign at_bottom = (cursor_row == ROW_LAST);

    // Logical rows are rotated by top_row; the wrap is a single compare-and-subtract.
    assign row_sum  = {1'b0, cursor_row} + {1'b0, top_row};
    assign phys_row = (row_sum >= ROW_NUM) ? 5'(row_sum - ROW_NUM) : row_sum[4:0];
    assign top_next = (top_row == ROW_LAST) ? 5'd0 : top_row + 5'd1;

    assign do_newline = (state == IDLE && accept && char_data == 8'h0A) ||
                        (state == WRITE && !stall && wr_advance && cursor_col == COL_LAST);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (init_pend)                          state_nxt = CLR_ALL;
                else if (do_newline && at_bottom)       state_nxt = CLR_LINE;
                else if (accept && (is_print || is_bs)) state_nxt = WRITE;
                else if (accept && is_ff)               state_nxt = CLR_ALL;
            end
            WRITE:    if (!stall) state_nxt = (do_newline && at_bottom) ? CLR_LINE : IDLE;
            CLR_LINE: if (!stall && clr_cnt == LINE_LAST) state_nxt = IDLE;
            CLR_ALL:  if (!stall && clr_cnt == CELL_LAST) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_addr = clr_cnt;
        case (state)
            WRITE:    wr_addr = ADDR_W'(phys_row) * COLS_A + ADDR_W'(cursor_col);
            CLR_LINE: wr_addr = ADDR_W'(line_row) * COLS_A + clr_cnt;
            default:  ;
        endcase
        vram_addr  = stall ? scan_addr : wr_addr;
        vram_we    = !stall && (state != IDLE);
        vram_wdata = (state == WRITE) ? wr_data : 8'h20;
        char_ready = (state == IDLE) && !init_pend && !Rst;
        busy       = (state != IDLE) || (init_pend && !Rst);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cursor_col <= 7'd0;
            cursor_row <= 5'd0;
            top_row    <= 5'd0;
            wr_data    <= 8'h20;
            wr_advance <= 1'b0;
            line_row   <= 5'd0;
            clr_cnt    <= '0;
            init_pend  <= INIT_CLEAR;
        end else begin
            if (state == IDLE) begin
                clr_cnt   <= '0;
                init_pend <= 1'b0;
                if (accept) begin
                    if (is_print) begin
                        wr_data    <= char_data;
                        wr_advance <= 1'b1;
                    end else if (is_bs) begin
                        wr_data    <= 8'h20;
                        wr_advance <= 1'b0;
                        cursor_col <= cursor_col - 7'd1;
                    end else if (char_data == 8'h0D) begin
                        cursor_col <= 7'd0;
                    end
                end
            end else if (!stall) begin
                clr_cnt <= (state == WRITE) ? '0 : clr_cnt + ADDR_W'(1);
                if (state == WRITE && wr_advance)
                    cursor_col <= (cursor_col == COL_LAST) ? 7'd0 : cursor_col + 7'd1;
                if (state == CLR_ALL && clr_cnt == CELL_LAST) begin
                    cursor_col <= 7'd0;
                    cursor_row <= 5'd0;
                    top_row    <= 5'd0;
                end
            end
            // Scrolling at the bottom reuses the old top physical row as the new bottom line.
            if (do_newline) begin
                if (at_bottom) begin
                    top_row  <= top_next;
                    line_row <= top_row;
                end else begin
                    cursor_row <= cursor_row + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_text_vram_ctrl.sv
// Bench for text_vram_ctrl: vector table, hand sequences and randomized bytes against a terminal model.
module tb_text_vram_ctrl;
    localparam int COLS = 80, ROWS = 30, ADDR_W = 12, CELLS = COLS * ROWS;

    logic              clk = 1'b0, rst = 1'b1;
    logic              char_valid = 1'b0;
    logic [7:0]        char_data = 8'h00;
    logic              char_ready;
    logic              scan_man = 1'b0, scan_rand_en = 1'b0, scan_rnd_req = 1'b0;
    logic [ADDR_W-1:0] scan_addr_man = '0, scan_rnd_addr = '0;
    logic              scan_req;
    logic [ADDR_W-1:0] scan_addr, vram_addr;
    logic [7:0]        vram_wdata;
    logic              vram_we, busy;
    logic [4:0]        top_row, cursor_row;
    logic [6:0]        cursor_col;

    assign scan_req  = scan_rand_en ? scan_rnd_req  : scan_man;
    assign scan_addr = scan_rand_en ? scan_rnd_addr : scan_addr_man;

    text_vram_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
        .Clk(clk), .Rst(rst), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready), .scan_req(scan_req), .scan_addr(scan_addr),
        .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we),
        .top_row(top_row), .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
    );

    // clock / reset
    initial forever #5 clk = ~clk;

    int checks = 0, passed = 0, wr_seen = 0;
    logic [19:0] exp_q[$];
    int m_col = 0, m_row = 0, m_top = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // reference model: terminal semantics with plain arithmetic
    function automatic int phys(input int r, input int c);
        return ((r + m_top) % ROWS) * COLS + c;
    endfunction

    task automatic push_w(input int a, input int d);
        exp_q.push_back({12'(a), 8'(d)});
    endtask

    task automatic m_newline();
        if (m_row < ROWS - 1) m_row++;
        else begin
            for (int c = 0; c < COLS; c++) push_w(m_top * COLS + c, 8'h20);
            m_top = (m_top + 1) % ROWS;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_w(phys(m_row, m_col), int'(b));
            if (m_col == COLS - 1) begin
                m_col = 0;
                m_newline();
            end else m_col++;
        end else if (b == 8'h0D) m_col = 0;
        else if (b == 8'h0A) m_newline();
        else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                push_w(phys(m_row, m_col), 8'h20);
            end
        end else if (b == 8'h0C) begin
            for (int a = 0; a < CELLS; a++) push_w(a, 8'h20);
            m_col = 0; m_row = 0; m_top = 0;
        end
    endtask

    task automatic model_reset_release();
        m_col = 0; m_row = 0; m_top = 0;
`ifdef VRAM_CLEAR_ON_RESET_EN
        for (int a = 0; a < CELLS; a++) push_w(a, 8'h20);
`endif
    endtask

    // scoreboard: every committed-looking write must match the head of exp_q
    initial forever begin
        logic [19:0] e;
        @(negedge clk);
        if (scan_req) begin
            chk("scan_we_low", int'(vram_we), 0);
            chk("scan_addr_pass", int'(vram_addr), int'(scan_addr));
        end
        if (vram_we) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: addr %0d data %02h, none expected", vram_addr, vram_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", int'(vram_addr), int'(e[19:8]));
                chk("write_data", int'(vram_wdata), int'(e[7:0]));
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        scan_rnd_req  = ($urandom_range(0, 3) == 0);
        scan_rnd_addr = ADDR_W'($urandom_range(0, CELLS - 1));
    end

    // drivers (called at posedge+1)
    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        model_byte(b);
        char_data  = b;
        char_valid = 1'b1;
        for (int i = 0; i < 8000 && !got; i++) begin
            @(negedge clk);
            got = char_ready;
        end
        if (!got) begin
            checks++;
            $display("FAIL send_timeout: char_ready stayed 0, required 1");
        end
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic wait_idle(output int busy_cyc);
        bit got = 1'b0;
        busy_cyc = 0;
        for (int i = 0; i < 8000 && !got; i++) begin
            @(negedge clk);
            if (!busy && char_ready) got = 1'b1;
            else busy_cyc++;
        end
        if (!got) begin
            checks++;
            $display("FAIL idle_timeout: busy=%0d char_ready=%0d, required 0/1", busy, char_ready);
        end
        chk("exp_q_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_col"}, int'(cursor_col), m_col);
        chk({tag, "_row"}, int'(cursor_row), m_row);
        chk({tag, "_top"}, int'(top_row), m_top);
    endtask

    typedef struct {
        logic [7:0] b;
        int         col;
        int         row;
        int         lat;
    } vec_t;

    initial begin
        vec_t vecs[11];
        logic [7:0] b;
        int r, bc, start;
        bit got;

        vecs[0]  = '{8'h41, 1, 0, 1};
        vecs[1]  = '{8'h42, 2, 0, 1};
        vecs[2]  = '{8'h0D, 0, 0, 0};
        vecs[3]  = '{8'h0A, 0, 1, 0};
        vecs[4]  = '{8'h08, 0, 1, 0};
        vecs[5]  = '{8'h78, 1, 1, 1};
        vecs[6]  = '{8'h08, 0, 1, 1};
        vecs[7]  = '{8'h07, 0, 1, 0};
        vecs[8]  = '{8'h7F, 0, 1, 0};
        vecs[9]  = '{8'h7E, 1, 1, 1};
        vecs[10] = '{8'h20, 2, 1, 1};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(char_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_we", int'(vram_we), 0);
        chk("rst_col", int'(cursor_col), 0);
        chk("rst_row", int'(cursor_row), 0);
        chk("rst_top", int'(top_row), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset_release();
        wait_idle(bc);

        // table-driven vectors, scanout idle
        for (int i = 0; i < 11; i++) begin
            send_byte(vecs[i].b);
            wait_idle(bc);
            chk($sformatf("vec%0d_col", i), int'(cursor_col), vecs[i].col);
            chk($sformatf("vec%0d_row", i), int'(cursor_row), vecs[i].row);
            chk($sformatf("vec%0d_top", i), int'(top_row), 0);
            chk($sformatf("vec%0d_ready_low", i), bc, vecs[i].lat);
        end

        // scanout holds the port for 5 cycles during a 'Z' write at (1,2)
        scan_man = 1'b1;
        scan_addr_man = 12'd7;
        send_byte(8'h5A);
        for (int i = 0; i < 5; i++) begin
            scan_addr_man = ADDR_W'($urandom_range(0, CELLS - 1));
            @(negedge clk);
            chk("stall_we", int'(vram_we), 0);
            chk("stall_addr", int'(vram_addr), int'(scan_addr_man));
            chk("stall_busy", int'(busy), 1);
            @(posedge clk);
            #1;
        end
        scan_man = 1'b0;
        @(negedge clk);
        chk("z_commit_we", int'(vram_we), 1);
        chk("z_commit_addr", int'(vram_addr), 82);
        chk("z_commit_data", int'(vram_wdata), 8'h5A);
        @(posedge clk);
        #1;
        wait_idle(bc);
        chk("z_col", int'(cursor_col), 3);

        // walk to (29,79), then 'Q' wraps and scrolls
        send_byte(8'h0D);
        wait_idle(bc);
        for (int i = 0; i < 28; i++) begin
            send_byte(8'h0A);
            wait_idle(bc);
        end
        for (int i = 0; i < 79; i++) begin
            send_byte(8'(8'h61 + i % 26));
            wait_idle(bc);
        end
        chk("pre_q_col", int'(cursor_col), 79);
        chk("pre_q_row", int'(cursor_row), 29);
        send_byte(8'h51);
        @(negedge clk);
        chk("q_addr", int'(vram_addr), 2399);
        chk("q_data", int'(vram_wdata), 8'h51);
        @(posedge clk);
        #1;
        wait_idle(bc);
        chk("scroll_clear_cycles", bc, 80);
        chk("scroll_col", int'(cursor_col), 0);
        chk("scroll_row", int'(cursor_row), 29);
        chk("scroll_top", int'(top_row), 1);

        // backspace on the rotated bottom row
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h62);
            wait_idle(bc);
        end
        send_byte(8'h08);
        @(negedge clk);
        chk("bs_addr", int'(vram_addr), 4);
        chk("bs_data", int'(vram_wdata), 8'h20);
        @(posedge clk);
        #1;
        wait_idle(bc);
        chk("bs_col", int'(cursor_col), 4);

        // form feed clears everything
        send_byte(8'h0C);
        wait_idle(bc);
        chk("ff_busy_cycles", bc, CELLS);
        chk("ff_col", int'(cursor_col), 0);
        chk("ff_row", int'(cursor_row), 0);
        chk("ff_top", int'(top_row), 0);

        // randomized bytes with random scanout contention
        scan_rand_en = 1'b1;
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      b = 8'($urandom_range(32, 126));
            else if (r < 80) b = 8'h0A;
            else if (r < 87) b = 8'h08;
            else if (r < 93) b = 8'h0D;
            else if (r < 99) b = 8'($urandom_range(128, 255));
            else             b = 8'h0C;
            send_byte(b);
            wait_idle(bc);
            chk_model("rand");
        end
        scan_rand_en = 1'b0;

        // reset in the middle of a full clear
        send_byte(8'h0D);
        wait_idle(bc);
        send_byte(8'h68);
        wait_idle(bc);
        send_byte(8'h69);
        wait_idle(bc);
        start = wr_seen;
        send_byte(8'h0C);
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            got = vram_we && (vram_addr == 12'd1000);
        end
        if (!got) begin
            checks++;
            $display("FAIL abort_reach: address 1000 never written, required a write");
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        chk("abort_write_count", wr_seen - start, 1001);
        @(negedge clk);
        chk("abort_we", int'(vram_we), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(char_ready), 0);
        chk_model("abort");
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset_release();
        wait_idle(bc);
        chk_model("post_abort");
`ifdef VRAM_CLEAR_ON_RESET_EN
        chk("post_abort_writes", wr_seen - start, 1001 + CELLS);
`else
        chk("post_abort_writes", wr_seen - start, 1001);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
